// File: rtl/t03_sprite_pkg.sv
// Shared types and constants for the sprite layer.
// Optional build macro T03_SPRITE_FLIP_EN is consumed by the files importing this package.
package t03_sprite_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 11;

  typedef logic [7:0]         color_t;   // RRRGGGBB
  typedef logic [COORD_W-1:0] coord_t;

  localparam color_t DEF_TRANSPARENT_KEY = 8'h00;
  localparam color_t DEF_BG_COLOR        = 8'h57;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t03_sprite_hit.sv
// One sprite channel: bounds test against the raster position and texel row/column.
// With T03_SPRITE_FLIP_EN a flip input mirrors the column.
module t03_sprite_hit
  import t03_sprite_pkg::*;
#(
  parameter int unsigned SPR_W   = 15,
  parameter int unsigned SPR_H   = 20,
  parameter int unsigned SCALE_X = 1,
  parameter int unsigned SCALE_Y = 5,
  parameter int unsigned COL_W   = width_of(SPR_W),
  parameter int unsigned ROW_W   = width_of(SPR_H)
) (
  input  logic [COORD_W-1:0] hcnt,
  input  logic [COORD_W-1:0] vcnt,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
`ifdef T03_SPRITE_FLIP_EN
  input  logic               flip,
`endif
  output logic               hit,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row
);

  localparam logic [11:0] PIX_W = 12'(SPR_W * SCALE_X);
  localparam logic [11:0] PIX_H = 12'(SPR_H * SCALE_Y);

  logic [11:0]      h12, v12, x12, y12, dx, dy;
  logic [COL_W-1:0] col_raw;

  // One extra bit keeps right/bottom edges near 2047 from wrapping.
  always_comb begin
    h12     = {1'b0, hcnt};
    v12     = {1'b0, vcnt};
    x12     = {1'b0, x};
    y12     = {1'b0, y};
    dx      = h12 - x12;
    dy      = v12 - y12;
    hit     = en && (h12 >= x12) && (h12 < x12 + PIX_W) &&
                    (v12 >= y12) && (v12 < y12 + PIX_H);
    col_raw = COL_W'(dx / 12'(SCALE_X));
    row     = ROW_W'(dy / 12'(SCALE_Y));
`ifdef T03_SPRITE_FLIP_EN
    col     = flip ? COL_W'(SPR_W - 1) - col_raw : col_raw;
`else
    col     = col_raw;
`endif
  end

endmodule

// File: rtl/t03_sprite_layer.sv
// Multi-sprite renderer: double-buffered channels, priority hit test, ROM fetch, 2-cycle colour pipe.
// Optional macro T03_SPRITE_FLIP_EN adds the wr_flip port and per-channel horizontal flip.
module t03_sprite_layer
  import t03_sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES     = 4,
  parameter int unsigned SPR_W           = 15,
  parameter int unsigned SPR_H           = 20,
  parameter int unsigned SCALE_X         = 1,
  parameter int unsigned SCALE_Y         = 5,
  parameter logic [7:0]  TRANSPARENT_KEY = DEF_TRANSPARENT_KEY,
  parameter logic [7:0]  BG_COLOR        = DEF_BG_COLOR,
  parameter int unsigned CH_W            = width_of(NUM_SPRITES),
  parameter int unsigned ADDR_W          = width_of(NUM_SPRITES * SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcnt,
  input  logic [10:0]       vcnt,
  input  logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [10:0]       wr_x,
  input  logic [10:0]       wr_y,
  input  logic              wr_en,
`ifdef T03_SPRITE_FLIP_EN
  input  logic              wr_flip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        color,
  output logic              hit,
  output logic [CH_W-1:0]   hit_ch,
  output logic              collision
);

  localparam int unsigned COL_W = width_of(SPR_W);
  localparam int unsigned ROW_W = width_of(SPR_H);

  logic [COORD_W-1:0]     sh_x  [NUM_SPRITES];
  logic [COORD_W-1:0]     sh_y  [NUM_SPRITES];
  logic [COORD_W-1:0]     act_x [NUM_SPRITES];
  logic [COORD_W-1:0]     act_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en, act_en;
`ifdef T03_SPRITE_FLIP_EN
  logic [NUM_SPRITES-1:0] sh_flip, act_flip;
`endif

  logic                   wr_take;
  logic [NUM_SPRITES-1:0] hits;
  logic [COL_W-1:0]       cols [NUM_SPRITES];
  logic [ROW_W-1:0]       rows [NUM_SPRITES];

  logic                   any_hit, multi_hit;
  logic [CH_W-1:0]        sel_ch;
  logic [COL_W-1:0]       sel_col;
  logic [ROW_W-1:0]       sel_row;
  logic [ADDR_W-1:0]      addr_nxt;

  logic                   s1_valid, s2_valid;
  logic [CH_W-1:0]        s1_ch, s2_ch;

  assign wr_ready = ~frame_start;
  assign wr_take  = wr_valid && wr_ready && (32'(wr_ch) < NUM_SPRITES);

  // Shadow/active channel registers; the frame_start copy shadows any write in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_en    <= '0;
      act_en   <= '0;
`ifdef T03_SPRITE_FLIP_EN
      sh_flip  <= '0;
      act_flip <= '0;
`endif
    end else if (frame_start) begin
      act_x    <= sh_x;
      act_y    <= sh_y;
      act_en   <= sh_en;
`ifdef T03_SPRITE_FLIP_EN
      act_flip <= sh_flip;
`endif
    end else if (wr_take) begin
      sh_x[wr_ch]    <= wr_x;
      sh_y[wr_ch]    <= wr_y;
      sh_en[wr_ch]   <= wr_en;
`ifdef T03_SPRITE_FLIP_EN
      sh_flip[wr_ch] <= wr_flip;
`endif
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    t03_sprite_hit #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .SCALE_X (SCALE_X),
      .SCALE_Y (SCALE_Y),
      .COL_W   (COL_W),
      .ROW_W   (ROW_W)
    ) u_hit (
      .hcnt (hcnt),
      .vcnt (vcnt),
      .x    (act_x[g]),
      .y    (act_y[g]),
      .en   (act_en[g]),
`ifdef T03_SPRITE_FLIP_EN
      .flip (act_flip[g]),
`endif
      .hit  (hits[g]),
      .col  (cols[g]),
      .row  (rows[g])
    );
  end

  // Lowest index wins; any later hitter marks an overlap.
  always_comb begin
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    sel_ch    = '0;
    sel_col   = '0;
    sel_row   = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (hits[i]) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end else begin
          any_hit = 1'b1;
          sel_ch  = CH_W'(i);
          sel_col = cols[i];
          sel_row = rows[i];
        end
      end
    end
    addr_nxt = ADDR_W'(32'(sel_ch) * SPR_W * SPR_H + 32'(sel_row) * SPR_W + 32'(sel_col));
  end

  // s1 tracks the address cycle, s2 the cycle rom_data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s2_valid  <= 1'b0;
      s2_ch     <= '0;
      color     <= '0;
      hit       <= 1'b0;
      hit_ch    <= '0;
      collision <= 1'b0;
    end else begin
      if (any_hit) rom_addr <= addr_nxt;
      s1_valid <= any_hit;
      s1_ch    <= sel_ch;
      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      hit      <= s2_valid;
      hit_ch   <= s2_valid ? s2_ch : '0;
      if (!s2_valid)                     color <= '0;
      else if (rom_data == TRANSPARENT_KEY) color <= BG_COLOR;
      else                               color <= rom_data;
      if (frame_start)    collision <= 1'b0;
      else if (multi_hit) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t03_sprite_layer.sv
// Self-checking bench for t03_sprite_layer: directed table, reset corner case, randomized vs. reference model.
module tb_t03_sprite_layer;

  localparam int NS = 4;
  localparam int SW = 15;
  localparam int SH = 20;
  localparam int SX = 1;
  localparam int SY = 5;
  localparam int AW = $clog2(NS * SW * SH);

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   hcnt, vcnt;
  logic          frame_start, wr_valid, wr_ready, wr_en;
  logic [1:0]    wr_ch;
  logic [10:0]   wr_x, wr_y;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    color;
  logic          hit;
  logic [1:0]    hit_ch;
  logic          collision;
`ifdef T03_SPRITE_FLIP_EN
  logic          wr_flip;
`endif

  t03_sprite_layer #(.NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .SCALE_X(SX), .SCALE_Y(SY)) dut (
    .clk         (clk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_en       (wr_en),
`ifdef T03_SPRITE_FLIP_EN
    .wr_flip     (wr_flip),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .color       (color),
    .hit         (hit),
    .hit_ch      (hit_ch),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM
  logic [7:0] rom_mem [NS*SW*SH];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Reference model state
  int  sh_x[NS], sh_y[NS], ac_x[NS], ac_y[NS];
  bit  sh_en[NS], ac_en[NS], sh_fl[NS], ac_fl[NS];
  bit  m_coll;
  int  m_addr;
  typedef struct { bit h; int ch; int addr; } pix_t;
  pix_t hist[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pix_t z;
    z.h = 0; z.ch = 0; z.addr = 0;
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_fl[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0; ac_fl[i] = 0;
    end
    m_coll = 0;
    m_addr = 0;
    hist = {};
    hist.push_back(z);
    hist.push_back(z);
  endtask

  function automatic pix_t probe(input int h, input int v, output int nhit);
    pix_t p;
    int c;
    p.h = 0; p.ch = 0; p.addr = 0;
    nhit = 0;
    for (int i = 0; i < NS; i++) begin
      if (ac_en[i] && h >= ac_x[i] && h < ac_x[i] + SW*SX && v >= ac_y[i] && v < ac_y[i] + SH*SY) begin
        nhit++;
        if (!p.h) begin
          c = (h - ac_x[i]) / SX;
          if (ac_fl[i]) c = SW - 1 - c;
          p.h = 1;
          p.ch = i;
          p.addr = i*SW*SH + ((v - ac_y[i]) / SY) * SW + c;
        end
      end
    end
    return p;
  endfunction

  task automatic cycle(input bit fs, input bit wv, input int ch, input int x, input int y,
                       input bit en, input bit fl, input int h, input int v);
    pix_t p, e;
    int n;
    logic [7:0] d, ec;
    @(negedge clk);
    frame_start = fs; wr_valid = wv; wr_ch = 2'(ch); wr_x = 11'(x); wr_y = 11'(y); wr_en = en;
`ifdef T03_SPRITE_FLIP_EN
    wr_flip = fl;
`endif
    hcnt = 11'(h); vcnt = 11'(v);
    #1 chk("wr_ready", wr_ready, !fs);
    p = probe(h, v, n);
    @(posedge clk);
    if (fs) begin
      ac_x = sh_x; ac_y = sh_y; ac_en = sh_en; ac_fl = sh_fl;
      m_coll = 0;
    end else begin
      if (wv) begin
        sh_x[ch] = x; sh_y[ch] = y; sh_en[ch] = en;
`ifdef T03_SPRITE_FLIP_EN
        sh_fl[ch] = fl;
`endif
      end
      if (n >= 2) m_coll = 1;
    end
    if (p.h) m_addr = p.addr;
    hist.push_back(p);
    e = hist.pop_front();
    d = rom_mem[e.addr];
    ec = !e.h ? 8'h00 : (d == 8'h00 ? 8'h57 : d);
    #1;
    chk("rom_addr", rom_addr, m_addr);
    chk("hit", hit, e.h);
    chk("color", color, ec);
    if (e.h) chk("hit_ch", hit_ch, e.ch);
    chk("collision", collision, m_coll);
  endtask

  typedef enum int { OP_FRAME, OP_WRITE, OP_WRFS, OP_WRFS_HOLD, OP_PIX } op_t;
  typedef struct {
    op_t op; int ch; int x; int y; bit en; int h; int v;
    int e_addr; bit e_hit; int e_col; int e_ch; bit e_coll;
  } vec_t;
  vec_t vecs[$];
  vec_t t;

  function automatic vec_t mk(input op_t op, input int ch, input int x, input int y, input bit en,
                              input int h, input int v, input int ea, input bit eh, input int ecol,
                              input int ech, input bit ecoll);
    vec_t r;
    r.op = op; r.ch = ch; r.x = x; r.y = y; r.en = en; r.h = h; r.v = v;
    r.e_addr = ea; r.e_hit = eh; r.e_col = ecol; r.e_ch = ech; r.e_coll = ecoll;
    return r;
  endfunction

  bit rfs, rwv, ren, rfl;
  int rch, rx, ry, rs, rh, rv;

  initial begin
    rst = 1'b1; frame_start = 0; wr_valid = 0; wr_ch = '0; wr_x = '0; wr_y = '0; wr_en = 0;
`ifdef T03_SPRITE_FLIP_EN
    wr_flip = 0;
`endif
    hcnt = '0; vcnt = '0;
    for (int i = 0; i < NS*SW*SH; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rom_mem[0] = 8'hE0; rom_mem[299] = 8'h00; rom_mem[35] = 8'h1C; rom_mem[300] = 8'hAA;
    model_reset();

    #1;
    chk("rst_color", color, 8'h00);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hit_ch", hit_ch, 2'd0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // op, ch, x, y, en, h, v, exp rom_addr, exp hit, exp color, exp hit_ch, exp collision
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 100,  50,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_WRITE,     0, 100, 50, 1, 0, 0,    0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 100,  50,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 100,  50,   0, 1, 8'hE0, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 114, 149, 299, 1, 8'h57, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 115, 149, 299, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 114, 150, 299, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0,  99,  50, 299, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_WRITE,     1, 100, 50, 1, 0, 0,    0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 105,  60,  35, 1, 8'h1C, 0, 0));
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 105,  60,  35, 1, 8'h1C, 0, 1));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0,   0,   0,  35, 0, 8'h00, 0, 1));
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0,   0,   0,  35, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_WRFS,      1, 500, 50, 1, 0, 0,    0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 500,  50,  35, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_WRFS_HOLD, 0, 300, 50, 1, 0, 0,    0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 300,  50,  35, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_FRAME,     0, 0, 0, 0,   0,   0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 300,  50,   0, 1, 8'hE0, 0, 0));
    vecs.push_back(mk(OP_PIX,       0, 0, 0, 0, 100,  50, 300, 1, 8'hAA, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      case (t.op)
        OP_FRAME: cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        OP_WRITE: cycle(0, 1, t.ch, t.x, t.y, t.en, 0, 0, 0);
        OP_WRFS:  cycle(1, 1, t.ch, t.x, t.y, t.en, 0, 0, 0);
        OP_WRFS_HOLD: begin
          cycle(1, 1, t.ch, t.x, t.y, t.en, 0, 0, 0);
          cycle(0, 1, t.ch, t.x, t.y, t.en, 0, 0, 0);
        end
        default: begin
          cycle(0, 0, 0, 0, 0, 0, 0, t.h, t.v);
          chk($sformatf("tbl%0d_rom_addr", i), rom_addr, t.e_addr);
          cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
          cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
          chk($sformatf("tbl%0d_hit", i), hit, t.e_hit);
          chk($sformatf("tbl%0d_color", i), color, t.e_col);
          if (t.e_hit) chk($sformatf("tbl%0d_hit_ch", i), hit_ch, t.e_ch);
          chk($sformatf("tbl%0d_collision", i), collision, t.e_coll);
        end
      endcase
    end

    // Overlap at ch0's spot, then asynchronous reset mid-sprite
    cycle(0, 1, 1, 300, 50, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 301, 55);
    chk("pre_rst_hit", hit, 1'b1);
    chk("pre_rst_collision", collision, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_color", color, 8'h00);
    chk("async_rst_hit", hit, 1'b0);
    chk("async_rst_collision", collision, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 301, 55);
    chk("post_rst_no_hit", hit, 1'b0);
    cycle(0, 1, 0, 300, 50, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 301, 55);
    chk("post_rst_no_fs_no_hit", hit, 1'b0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 301, 55);
    chk("post_rst_rewrite_hit", hit, 1'b1);

    // Randomized traffic, including positions near the 2047 edge
    for (int k = 0; k < 2500; k++) begin
      rfs = ($urandom_range(0, 99) == 0);
      rwv = ($urandom_range(0, 5) == 0);
      rch = $urandom_range(0, NS - 1);
      rx  = ($urandom_range(0, 9) == 0) ? $urandom_range(2030, 2047) : $urandom_range(0, 200);
      ry  = ($urandom_range(0, 9) == 0) ? $urandom_range(1950, 2047) : $urandom_range(0, 200);
      ren = ($urandom_range(0, 3) != 0);
      rfl = $urandom_range(0, 1);
      rs  = $urandom_range(0, NS - 1);
      rh  = ac_x[rs] + $urandom_range(0, SW*SX + 5) - 3;
      rv  = ac_y[rs] + $urandom_range(0, SH*SY + 5) - 3;
      if (rh < 0) rh = 0;
      if (rh > 2047) rh = 2047;
      if (rv < 0) rv = 0;
      if (rv > 2047) rv = 2047;
      cycle(rfs, rwv, rch, rx, ry, ren, rfl, rh, rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
